// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment display path: the 4-bit digit
// code type and the non-numeric code points understood by the decoder.
package seg_pkg;

    typedef logic [3:0] seg_code_t;

    localparam seg_code_t SEG_MINUS = 4'hA;
    localparam seg_code_t SEG_BLANK = 4'hB;
    localparam seg_code_t SEG_CLOSE = 4'hC;

    // Fills a packed multi-digit bus with blank codes (reset image of the
    // snapshot buffer).
    function automatic logic [31:0] seg_all_blank();
        return {8{SEG_BLANK}};
    endfunction

endpackage

// File: rtl/seg_scan_if.sv
// Display-side bundle of the scan driver.
//   digits_in  : packed digit codes, digit i at [4i+3:4i]
//   blink_mask : per-digit blink enable
//   en         : display enable
//   num        : code of the selected digit (to the segment decoder)
//   dig_sel    : one-hot digit enable (to the display)
// master = producer of digit data, slave = seg_scan.
interface seg_scan_if
    import seg_pkg::*;
#(
    parameter int DIGITS = 8
);
    logic [4*DIGITS-1:0] digits_in;
    logic [DIGITS-1:0]   blink_mask;
    logic                en;
    seg_code_t           num;
    logic [DIGITS-1:0]   dig_sel;

    modport master (
        output digits_in,
        output blink_mask,
        output en,
        input  num,
        input  dig_sel
    );

    modport slave (
        input  digits_in,
        input  blink_mask,
        input  en,
        output num,
        output dig_sel
    );
endinterface

// File: rtl/seg_scan_tick.sv
// Modulo-N counter with synchronous active-high reset. Counts when en is
// high; tick is high during the cycle in which the counter will wrap, so a
// consumer sampling it on the same edge sees the wrap edge.
//   clk, rst : clock, synchronous reset
//   en       : count enable
//   tick     : one-cycle pulse on the wrap cycle
module scan_tick #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);
    localparam int W = (N > 1) ? $clog2(N) : 1;
    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
        end
    end

    assign tick = en && (cnt == LAST);
endmodule

// File: rtl/seg_scan.sv
// Time-multiplexed scan driver for a multi-digit seven-segment display.
// Digit codes and blink mask are snapshotted once per frame so a frame never
// shows a mix of old and new values. Each digit is selected for REFRESH_DIV
// clocks; masked digits blank during the odd blink half-period.
//   clk, rst : clock, synchronous active-high reset
//   bus      : seg_scan_if slave (digits_in, blink_mask, en -> num, dig_sel)
module seg_scan
    import seg_pkg::*;
#(
    parameter int DIGITS       = 8,
    parameter int REFRESH_DIV  = 100_000,
    parameter int BLINK_FRAMES = 250
) (
    input  logic         clk,
    input  logic         rst,
    seg_scan_if.slave    bus
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic                div_wrap;
    logic                frame_end;
    logic                fcnt_wrap;
    logic [IW-1:0]       idx;
    logic [4*DIGITS-1:0] digit_buf;
    logic [DIGITS-1:0]   mask_buf;
    logic                phase;
    seg_code_t           cur_code;

    scan_tick #(.N(REFRESH_DIV)) u_div (
        .clk  (clk),
        .rst  (rst),
        .en   (1'b1),
        .tick (div_wrap)
    );

    assign frame_end = div_wrap && (idx == IDX_LAST);

    scan_tick #(.N(BLINK_FRAMES)) u_frame (
        .clk  (clk),
        .rst  (rst),
        .en   (frame_end),
        .tick (fcnt_wrap)
    );

    assign cur_code = digit_buf[{idx, 2'b00} +: 4];

    always_ff @(posedge clk) begin
        if (rst) begin
            idx         <= '0;
            digit_buf   <= {DIGITS{SEG_BLANK}};
            mask_buf    <= '0;
            phase       <= 1'b0;
            bus.num     <= SEG_BLANK;
            bus.dig_sel <= '0;
        end else begin
            if (div_wrap) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
            end
            if (frame_end) begin
                digit_buf <= bus.digits_in;
                mask_buf  <= bus.blink_mask;
            end
            if (fcnt_wrap) begin
                phase <= ~phase;
            end

            // Outputs reflect this cycle's idx/buffer/phase, giving the
            // 1-cycle registered latency seen by the decoder.
            if (!bus.en) begin
                bus.dig_sel <= '0;
                bus.num     <= SEG_BLANK;
            end else begin
                bus.dig_sel <= DIGITS'(1) << idx;
                bus.num     <= (phase && mask_buf[idx]) ? SEG_BLANK : cur_code;
            end
        end
    end
endmodule

// File: tb/tb_seg_scan.sv
module tb_seg_scan;
    import seg_pkg::*;

    localparam int D  = 8;
    localparam int R  = 4;
    localparam int BF = 2;
    localparam int F  = D * R;

    logic clk = 1'b0;
    logic rst;

    seg_scan_if #(.DIGITS(D)) bus ();

    seg_scan #(
        .DIGITS       (D),
        .REFRESH_DIV  (R),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: position in time since reset determines everything.
    int          t;
    logic [31:0] m_buf;
    logic [7:0]  m_mask;
    logic [3:0]  exp_num;
    logic [7:0]  exp_sel;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t);
        end
    endtask

    task automatic model_edge();
        int i, f, ph;
        logic [3:0] d;
        if (rst) begin
            exp_num = SEG_BLANK;
            exp_sel = '0;
            t       = 0;
            m_buf   = 32'hBBBB_BBBB;
            m_mask  = '0;
        end else begin
            i  = (t / R) % D;
            f  = t / F;
            ph = (f / BF) % 2;
            d  = 4'((m_buf >> (4 * i)) & 32'hF);
            exp_sel = bus.en ? 8'(1 << i) : 8'h00;
            if (!bus.en || (ph == 1 && m_mask[i])) exp_num = SEG_BLANK;
            else                                   exp_num = d;
            if (t % F == F - 1) begin
                m_buf  = bus.digits_in;
                m_mask = bus.blink_mask;
            end
            t++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("num", 32'(bus.num), 32'(exp_num));
        chk("dig_sel", 32'(bus.dig_sel), 32'(exp_sel));
        chk("onehot0", 32'($onehot0(bus.dig_sel)), 32'd1);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        rst            = 1'b1;
        bus.digits_in  = 32'h7654_3210;
        bus.blink_mask = '0;
        bus.en         = 1'b1;
        t              = 0;
        run(3);
        chk("rst_num", 32'(bus.num), 32'hB);
        chk("rst_sel", 32'(bus.dig_sel), 32'h0);

        // Reset release and first frames
        rst = 1'b0;
        step();
        chk("first_sel", 32'(bus.dig_sel), 32'h01);
        chk("first_num", 32'(bus.num), 32'hB);
        run(3);
        step();
        chk("second_sel", 32'(bus.dig_sel), 32'h02);
        run(F - 5 + 1);
        chk("frame1_d0", 32'(bus.num), 32'h0);
        run(15);

        // Tearing guard: change mid-frame 1
        bus.digits_in = 32'hBBBB_BBA9;
        run(16 + F);

        // Blink
        bus.blink_mask = 8'h01;
        bus.digits_in  = 32'h0000_0005;
        run(F * 8);

        // Enable drop mid-digit
        run(2);
        bus.en = 1'b0;
        run(3);
        chk("en_off_sel", 32'(bus.dig_sel), 32'h0);
        chk("en_off_num", 32'(bus.num), 32'hB);
        bus.en = 1'b1;
        run(40);

        // Reset mid-frame while idx = 5
        begin
            int guard = 0;
            while (((t / R) % D) != 5 && guard < 2 * F) begin
                step();
                guard++;
            end
            chk("reach_idx5", 32'(((t / R) % D) == 5), 32'd1);
        end
        rst = 1'b1;
        step();
        chk("midrst_sel", 32'(bus.dig_sel), 32'h0);
        rst = 1'b0;
        bus.digits_in  = 32'h7654_3210;
        bus.blink_mask = '0;
        step();
        chk("restart_sel", 32'(bus.dig_sel), 32'h01);
        run(2 * F);

        // Random soak
        for (int k = 0; k < 10000; k++) begin
            bus.digits_in  = $urandom;
            bus.blink_mask = 8'($urandom_range(0, 255));
            bus.en         = ($urandom_range(0, 9) != 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
